// File: rtl/clock_gater_pkg.sv
// Shared definitions for the clock gater bank: channel state encoding,
// default hold-off and the parameter range check used at elaboration.
package clock_gater_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    DRAIN = 2'd2
  } gate_state_e;

  localparam int unsigned HOLD_DEFAULT   = 3;
  localparam int unsigned HOLD_W_DEFAULT = 4;

  // True when the hold-off count fits in the counter width.
  function automatic bit hold_range_ok(input int unsigned hold, input int unsigned width);
    if (width >= 32) return 1'b1;
    return hold < (32'd1 << width);
  endfunction

endpackage

// File: rtl/clock_gater_chan.sv
// One gated channel: request FSM with hold-off counter, plus the
// low-phase-transparent latch that makes the gate output glitch-free.
module clock_gater_chan
  import clock_gater_pkg::*;
#(
  parameter bit          INIT        = 1'b1,
  parameter int unsigned HOLD_W      = HOLD_W_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic cond,
  input  logic gate_en,
  output logic gate_q,
  output logic gate_out
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  gate_state_e       state;
  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT ? ON : OFF;
      cnt    <= '0;
      gate_q <= INIT;
    end else begin
      unique case (state)
        OFF: begin
          if (cond) begin
            state  <= ON;
            gate_q <= 1'b1;
          end
        end
        ON: begin
          if (!cond) begin
            if (HOLD_CYCLES == 0) begin
              state  <= OFF;
              gate_q <= 1'b0;
            end else begin
              state <= DRAIN;
              cnt   <= HOLD_LOAD;
            end
          end
        end
        DRAIN: begin
          // A re-assert during drain returns to ON without the gate ever dropping.
          if (cond) begin
            state <= ON;
            cnt   <= '0;
          end else if (cnt == CNT_ONE) begin
            state  <= OFF;
            cnt    <= '0;
            gate_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= OFF;
          cnt    <= '0;
          gate_q <= 1'b0;
        end
      endcase
    end
  end

  // Transparent only while clk is low, so the output is stable across every high phase.
  always_latch begin
    if (!clk) gate_out = gate_en;
  end

  a_drain_cnt: assert property (@(posedge clk) disable iff (rst)
    (state == DRAIN) |-> (cnt != '0));
  a_gate_state: assert property (@(posedge clk) disable iff (rst)
    gate_q == (state != OFF));

endmodule

// File: rtl/clock_gater_bank.sv
// NCH independent glitch-free clock gates sharing one oscillator.
// Define CLOCK_GATER_BYPASS_EN to add TEST_MODE, which forces every gate open.
module clock_gater_bank
  import clock_gater_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter bit          INIT        = 1'b1,
  parameter int unsigned HOLD_W      = HOLD_W_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
`ifdef CLOCK_GATER_BYPASS_EN
  input  logic           TEST_MODE,
`endif
  input  logic [NCH-1:0] COND,
  output logic           CLK_OUT,
  output logic [NCH-1:0] CLK_GATE_OUT,
  output logic [NCH-1:0] GATE_ON,
  output logic           ALL_OFF
);

  if (!hold_range_ok(HOLD_CYCLES, HOLD_W)) begin : g_bad_hold
    $error("clock_gater_bank: HOLD_CYCLES does not fit in HOLD_W bits");
  end
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("clock_gater_bank: NCH must be 1..32");
  end

  logic           bypass;
  logic [NCH-1:0] gate_en;

`ifdef CLOCK_GATER_BYPASS_EN
  assign bypass = TEST_MODE;
`else
  assign bypass = 1'b0;
`endif

  // Bypass acts only on the latch input, so status outputs keep showing FSM state.
  assign gate_en = GATE_ON | {NCH{bypass}};
  assign CLK_OUT = CLK;
  assign ALL_OFF = &(~GATE_ON);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clock_gater_chan #(
      .INIT       (INIT),
      .HOLD_W     (HOLD_W),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .cond    (COND[i]),
      .gate_en (gate_en[i]),
      .gate_q  (GATE_ON[i]),
      .gate_out(CLK_GATE_OUT[i])
    );
  end

endmodule

// File: doc/clock_gater_bank.md
Name: clock_gater_bank

Overview:
- Parametrised multi-channel successor to the single-channel clock gater.
- One free-running oscillator feeds NCH independent gate outputs.
- Each gate follows a registered per-channel condition, with programmable hold-off so short idle gaps do not toggle the gate.
- Gate outputs change only while CLK is low, so they are glitch-free.
- Sits at the clock-domain boundary; consumers use CLK_OUT plus their CLK_GATE_OUT bit.

Parameters:
- NCH, 4: number of gated channels (1..32).
- INIT, 1: gate state of every channel after reset (1 = ON, 0 = OFF).
- HOLD_W, 4: width of the per-channel hold-off counter.
- HOLD_CYCLES, 3: extra rising edges delivered after the condition drops; 0..2^HOLD_W-1.

Ports:
- CLK  input  1  oscillator; sole clock.
- RST  input  1  synchronous reset, active-high.
- COND  input  NCH  per-channel gate request, sampled on posedge CLK.
- CLK_OUT  output  1  equals CLK; never stops.
- CLK_GATE_OUT  output  NCH  per-channel gate; changes only while CLK=0.
- GATE_ON  output  NCH  registered gate state (gate_q) in the CLK domain.
- ALL_OFF  output  1  combinational AND of ~gate_q across all channels.

Behaviour:
- Interface: one clock (CLK). Reset (RST) is synchronous and active-high.
- Per-channel FSM states: OFF, ON, DRAIN. Registers: state, cnt[HOLD_W-1:0], gate_q. Gate is 1 in ON and DRAIN, 0 in OFF.
- Reset: at a posedge with RST=1, state becomes ON if INIT else OFF; cnt=0; gate_q=INIT. RST overrides COND and aborts any DRAIN mid-count.
- OFF: COND=1 goes to ON, else stays OFF.
- ON:
  - COND=1 stays ON.
  - COND=0 with HOLD_CYCLES=0 goes to OFF.
  - COND=0 otherwise goes to DRAIN with cnt=HOLD_CYCLES.
- DRAIN:
  - COND=1 goes to ON, cnt=0 (re-assert cancels drain with no gate dip).
  - COND=0 with cnt==1 goes to OFF, cnt=0.
  - COND=0 otherwise decrements cnt.
- Timing, assert: COND=1 sampled at edge k gives gate_q=1 after k. CLK_GATE_OUT rises in the low phase after k. First gated rising edge is k+1.
- Timing, deassert: COND=0 sampled at edge k delivers exactly HOLD_CYCLES further gated edges (k+1..k+HOLD_CYCLES). CLK_GATE_OUT falls in the low phase after edge k+HOLD_CYCLES.
- CLK_GATE_OUT model: a latch transparent while CLK=0, capturing gate_q. It holds its value while CLK=1.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- CLK_OUT is always CLK; there is no oscillator stop.

Optional Feature:
- Macro: CLOCK_GATER_BYPASS_EN.
- With the macro defined:
  - Adds input TEST_MODE (1 bit).
  - TEST_MODE=1 forces every CLK_GATE_OUT high, still through the low-phase latch.
  - FSM, GATE_ON and ALL_OFF keep normal operation, so status reflects functional state.
- Without the macro: no TEST_MODE port; gates driven purely by the FSMs.

Decomposition:
- Package clock_gater_pkg holds:
  - the state enum (OFF=2'd0, ON=2'd1, DRAIN=2'd2);
  - a default-HOLD localparam;
  - a hold-range check function used by an elaboration-time assertion (HOLD_CYCLES < 2**HOLD_W).
- Sub-module clock_gater_chan: one FSM, counter and output latch. The bank is a generate loop of NCH instances plus the ALL_OFF reduction and the bypass mux.

Test Plan:
- Reset, INIT=1, COND=0, HOLD_CYCLES=3:
  - GATE_ON=4'hF right after reset release.
  - Each channel drops after 3 further edges.
  - ALL_OFF=1 after the 4th edge.
- Assert, INIT=0, COND[2] pulsed 1 for one cycle, HOLD=3:
  - CLK_GATE_OUT[2] high for exactly 4 gated rising edges.
  - All other bits stay 0.
- Drain cancel: COND[0] 1 to 0 for 2 cycles, then back to 1, HOLD=3 → CLK_GATE_OUT[0] never falls; state returns to ON.
- HOLD_CYCLES=0: COND[1] falls at edge k → CLK_GATE_OUT[1] low in the low phase after k; edge k+1 is suppressed.
- Reset mid-DRAIN, INIT=0: RST asserted while cnt=2 → gate_q=0 after that edge; the drain does not complete.
- Glitch check with CLOCK_GATER_BYPASS_EN: toggle COND and TEST_MODE mid-high-phase → CLK_GATE_OUT never changes while CLK=1. TEST_MODE=1 gives 4'hF at the next low phase.
